// File: rtl/unidade_controle_pkg.sv
// Shared constants for the control unit, bus source multiplexer and datapath:
// opcodes, sequencing states, bus select codes and ALU operation codes.
package pacote_controle;

  localparam int N_REGS_DEFAULT = 8;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } estado_t;

  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_MVI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_MVNZ = 4'd5;

  // Codes 0..7 on the bus select address r0..r7 directly.
  localparam logic [3:0] SEL_IMM = 4'd8;
  localparam logic [3:0] SEL_R   = 4'd9;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;

  function automatic logic eh_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

endpackage

// File: rtl/unidade_controle_decodificador_3x8.sv
// 3-to-8 one-hot decoder producing the register load enables, gated by i_en.
module decodificador_3x8 (
  input  logic       i_en,
  input  logic [2:0] i_addr,
  output logic [7:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_addr] = 1'b1;
  end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: mv/mvi in two cycles, add/sub/and in four.
// Optional feature macro: CONTROLE_MVNZ_EN (opcode 5 = conditional move on g_nz).
module unidade_controle
  import pacote_controle::*;
#(
  parameter int N_REGS = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [15:0]       din,
  input  logic              g_nz,
  output logic [3:0]        select,
  output logic [N_REGS-1:0] reg_en,
  output logic              ir_en,
  output logic              a_en,
  output logic              r_en,
  output logic [1:0]        alu_op,
  output logic              done
);

  estado_t     r_estado;
  estado_t     w_prox_estado;
  logic [15:0] r_ir;
  logic [3:0]  w_op;
  logic [2:0]  w_rx;
  logic [2:0]  w_ry;
  logic        w_wr_en;
  logic        w_unused;

  assign w_op = r_ir[15:12];
  assign w_rx = r_ir[11:9];
  assign w_ry = r_ir[8:6];

`ifdef CONTROLE_MVNZ_EN
  assign w_unused = ^r_ir[5:0];
`else
  assign w_unused = ^{g_nz, r_ir[5:0]};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= T0;
      r_ir     <= '0;
    end else begin
      r_estado <= w_prox_estado;
      if (r_estado == T0 && run) r_ir <= din;
    end
  end

  // ir_en is masked by reset so that every output reads 0 while reset is held.
  always_comb begin
    w_prox_estado = r_estado;
    select        = 4'd0;
    w_wr_en       = 1'b0;
    ir_en         = 1'b0;
    a_en          = 1'b0;
    r_en          = 1'b0;
    alu_op        = ALU_ADD;
    done          = 1'b0;
    case (r_estado)
      T0: begin
        ir_en = run & ~reset;
        if (run) w_prox_estado = T1;
      end
      T1: begin
        w_prox_estado = T0;
        case (w_op)
          OP_MV: begin
            select  = {1'b0, w_ry};
            w_wr_en = 1'b1;
            done    = 1'b1;
          end
          OP_MVI: begin
            select  = SEL_IMM;
            w_wr_en = 1'b1;
            done    = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            select        = {1'b0, w_rx};
            a_en          = 1'b1;
            w_prox_estado = T2;
          end
`ifdef CONTROLE_MVNZ_EN
          OP_MVNZ: begin
            select  = {1'b0, w_ry};
            w_wr_en = g_nz;
            done    = 1'b1;
          end
`endif
          default: done = 1'b1;
        endcase
      end
      T2: begin
        select        = {1'b0, w_ry};
        r_en          = 1'b1;
        w_prox_estado = T3;
        case (w_op)
          OP_SUB:  alu_op = ALU_SUB;
          OP_AND:  alu_op = ALU_AND;
          default: alu_op = ALU_ADD;
        endcase
      end
      T3: begin
        select        = SEL_R;
        w_wr_en       = 1'b1;
        done          = 1'b1;
        w_prox_estado = T0;
      end
      default: w_prox_estado = T0;
    endcase
  end

  decodificador_3x8 u_decodificador (
    .i_en    (w_wr_en),
    .i_addr  (w_rx),
    .o_onehot(reg_en)
  );

endmodule
